// File: rtl/artemis_ddr3_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : artemis_ddr3_port_arbiter
// Description : Round-robin share of one MCB user port between two burst
//               requesters; sequences write-data/command and command/read-data.
// Revision    : 1.0 - initial release
// ============================================================================
module artemis_ddr3_port_arbiter #(
  parameter int RD_TIMEOUT = 256,
  parameter int TO_WIDTH   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        calibration_done,
  input  logic        r0_req,
  input  logic        r0_write,
  input  logic [29:0] r0_addr,
  input  logic [5:0]  r0_bl,
  output logic        r0_gnt,
  input  logic [31:0] r0_wr_data,
  input  logic [3:0]  r0_wr_mask,
  input  logic        r0_wr_stb,
  output logic        r0_wr_rdy,
  output logic [31:0] r0_rd_data,
  output logic        r0_rd_stb,
  output logic        r0_done,
  output logic        r0_error,
  input  logic        r1_req,
  input  logic        r1_write,
  input  logic [29:0] r1_addr,
  input  logic [5:0]  r1_bl,
  output logic        r1_gnt,
  input  logic [31:0] r1_wr_data,
  input  logic [3:0]  r1_wr_mask,
  input  logic        r1_wr_stb,
  output logic        r1_wr_rdy,
  output logic [31:0] r1_rd_data,
  output logic        r1_rd_stb,
  output logic        r1_done,
  output logic        r1_error,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        wr_en,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_data,
  input  logic        wr_full,
  input  logic        wr_underrun,
  input  logic        wr_error,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  input  logic        rd_overflow,
  input  logic        rd_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CMD  = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [TO_WIDTH-1:0] c_to_last = TO_WIDTH'(RD_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_last_grant;
  logic [27:0]           r_addr;
  logic [5:0]            r_bl;
  logic [5:0]            r_cnt;
  logic [TO_WIDTH-1:0]   r_timeout;
  logic                  r_err;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic [31:0]           r_rd_data;
  logic                  r_rd_stb;

  logic                  w_start;
  logic                  w_sel;
  logic                  w_sel_write;
  logic                  w_own_stb;
  logic [31:0]           w_own_data;
  logic [3:0]            w_own_mask;
  logic                  w_fault;
  logic                  w_cnt_last;
  logic                  w_to_hit;
  logic                  w_unused;

  // Tie goes to the requester that did not own the previous transfer
  assign w_start     = calibration_done & (r0_req | r1_req);
  assign w_sel       = (r0_req & r1_req) ? ~r_last_grant : r1_req;
  assign w_sel_write = w_sel ? r1_write : r0_write;
  assign w_own_stb   = r_owner ? r1_wr_stb  : r0_wr_stb;
  assign w_own_data  = r_owner ? r1_wr_data : r0_wr_data;
  assign w_own_mask  = r_owner ? r1_wr_mask : r0_wr_mask;
  assign w_fault     = wr_underrun | wr_error | rd_overflow | rd_error;
  assign w_cnt_last  = (r_cnt == r_bl);
  assign w_to_hit    = (r_timeout == c_to_last);
  assign w_unused    = ^{r0_addr[1:0], r1_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    cmd_en        = 1'b0;
    cmd_instr     = 3'b000;
    cmd_bl        = 6'd0;
    cmd_byte_addr = 30'd0;
    wr_en         = 1'b0;
    wr_mask       = 4'd0;
    wr_data       = 32'd0;
    rd_en         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = w_sel_write ? S_WR_DATA : S_RD_CMD;
      end
      S_WR_DATA: begin
        wr_data = w_own_data;
        wr_mask = w_own_mask;
        wr_en   = w_own_stb & ~wr_full;
        if (wr_en && w_cnt_last) w_next = S_WR_CMD;
      end
      S_WR_CMD: begin
        cmd_instr     = 3'b000;
        cmd_bl        = r_bl;
        cmd_byte_addr = {r_addr, 2'b00};
        cmd_en        = ~cmd_full;
        if (!cmd_full) w_next = S_DONE;
      end
      S_RD_CMD: begin
        cmd_instr     = 3'b001;
        cmd_bl        = r_bl;
        cmd_byte_addr = {r_addr, 2'b00};
        cmd_en        = ~cmd_full;
        if (!cmd_full) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        rd_en = ~rd_empty;
        if (rd_en && w_cnt_last)     w_next = S_DONE;
        else if (rd_empty && w_to_hit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= 28'd0;
      r_bl         <= 6'd0;
      r_cnt        <= 6'd0;
      r_timeout    <= '0;
      r_err        <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_rd_data    <= 32'd0;
      r_rd_stb     <= 1'b0;
    end else begin
      r_rd_stb <= rd_en;
      if (rd_en) r_rd_data <= rd_data;
      if (r_state != S_IDLE && w_fault) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_owner <= w_sel;
            r_addr  <= w_sel ? r1_addr[29:2] : r0_addr[29:2];
            r_bl    <= w_sel ? r1_bl : r0_bl;
            r_cnt   <= 6'd0;
            r_err   <= 1'b0;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
          end
        end
        S_WR_DATA: begin
          if (wr_en) r_cnt <= r_cnt + 6'd1;
        end
        S_RD_CMD: begin
          r_cnt     <= 6'd0;
          r_timeout <= '0;
        end
        S_RD_DATA: begin
          if (rd_en) begin
            r_cnt     <= r_cnt + 6'd1;
            r_timeout <= '0;
          end else begin
            r_timeout <= r_timeout + TO_WIDTH'(1);
            if (w_to_hit) r_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_last_grant <= r_owner;
          r_gnt0       <= 1'b0;
          r_gnt1       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign r0_gnt     = r_gnt0;
  assign r1_gnt     = r_gnt1;
  assign r0_wr_rdy  = (r_state == S_WR_DATA) & ~wr_full & ~r_owner;
  assign r1_wr_rdy  = (r_state == S_WR_DATA) & ~wr_full &  r_owner;
  assign r0_rd_stb  = r_rd_stb & ~r_owner;
  assign r1_rd_stb  = r_rd_stb &  r_owner;
  assign r0_rd_data = r_owner ? 32'd0 : r_rd_data;
  assign r1_rd_data = r_owner ? r_rd_data : 32'd0;
  assign r0_done    = (r_state == S_DONE) & ~r_owner;
  assign r1_done    = (r_state == S_DONE) &  r_owner;
  assign r0_error   = r0_done & r_err;
  assign r1_error   = r1_done & r_err;

endmodule
`default_nettype wire

// File: tb/tb_artemis_ddr3_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_artemis_ddr3_port_arbiter
// Description : Directed self-checking bench for the DDR3 port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_artemis_ddr3_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        calibration_done;
  logic        r0_req, r0_write, r0_wr_stb;
  logic [29:0] r0_addr;
  logic [5:0]  r0_bl;
  logic [31:0] r0_wr_data;
  logic [3:0]  r0_wr_mask;
  logic        r1_req, r1_write, r1_wr_stb;
  logic [29:0] r1_addr;
  logic [5:0]  r1_bl;
  logic [31:0] r1_wr_data;
  logic [3:0]  r1_wr_mask;
  logic        r0_gnt, r0_wr_rdy, r0_rd_stb, r0_done, r0_error;
  logic        r1_gnt, r1_wr_rdy, r1_rd_stb, r1_done, r1_error;
  logic [31:0] r0_rd_data, r1_rd_data;
  logic        cmd_en, cmd_full;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        wr_en, wr_full, wr_underrun, wr_error;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        rd_en, rd_empty, rd_overflow, rd_error;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  artemis_ddr3_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .calibration_done(calibration_done),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_bl(r0_bl),
    .r0_gnt(r0_gnt), .r0_wr_data(r0_wr_data), .r0_wr_mask(r0_wr_mask),
    .r0_wr_stb(r0_wr_stb), .r0_wr_rdy(r0_wr_rdy), .r0_rd_data(r0_rd_data),
    .r0_rd_stb(r0_rd_stb), .r0_done(r0_done), .r0_error(r0_error),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_bl(r1_bl),
    .r1_gnt(r1_gnt), .r1_wr_data(r1_wr_data), .r1_wr_mask(r1_wr_mask),
    .r1_wr_stb(r1_wr_stb), .r1_wr_rdy(r1_wr_rdy), .r1_rd_data(r1_rd_data),
    .r1_rd_stb(r1_rd_stb), .r1_done(r1_done), .r1_error(r1_error),
    .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
    .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
    .wr_en(wr_en), .wr_mask(wr_mask), .wr_data(wr_data), .wr_full(wr_full),
    .wr_underrun(wr_underrun), .wr_error(wr_error),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_error(rd_error)
  );

  always #5 clk = ~clk;

  // Read FIFO model: fill count set by the stimulus, pointer advanced on pops
  logic [31:0] rd_mem [16];
  int          rd_ptr = 0;
  int          rd_fill;
  assign rd_data  = rd_mem[rd_ptr % 16];
  assign rd_empty = (rd_ptr >= rd_fill);
  always @(posedge clk) if (rd_en) rd_ptr <= rd_ptr + 1;

  // Bus monitor, sampled mid-cycle
  int          cyc = 0, n_wr = 0, n_cmd = 0, n_bad = 0, n_done0 = 0;
  int          cmd_cyc = 0, last_stb_cyc = 0, n_stb1 = 0;
  logic [2:0]  m_instr;
  logic [5:0]  m_bl;
  logic [29:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] rd0_log[$], rd1_log[$];
  int          gnt_log[$];
  logic        p_g0 = 1'b0, p_g1 = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (wr_en) begin
      n_wr++;
      m_wdata = wr_data;
      m_wmask = wr_mask;
      if (wr_full) n_bad++;
    end
    if (cmd_en) begin
      n_cmd++;
      cmd_cyc = cyc;
      m_instr = cmd_instr;
      m_bl    = cmd_bl;
      m_addr  = cmd_byte_addr;
      if (cmd_full || wr_en) n_bad++;
    end
    if (r0_rd_stb) begin rd0_log.push_back(r0_rd_data); last_stb_cyc = cyc; end
    if (r1_rd_stb) begin rd1_log.push_back(r1_rd_data); n_stb1++; end
    if (r0_done) n_done0++;
    if (r0_gnt && !p_g0) gnt_log.push_back(0);
    if (r1_gnt && !p_g1) gnt_log.push_back(1);
    if (r0_gnt && r1_gnt) n_bad++;
    p_g0 = r0_gnt;
    p_g1 = r1_gnt;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int who, input int budget, output bit ok, output logic err);
    ok  = 1'b0;
    err = 1'bx;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (who == 0 ? r0_done : r1_done) begin
        ok  = 1'b1;
        err = (who == 0) ? r0_error : r1_error;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  bit   ok;
  logic err;
  int   b_wr, b_cmd, b_bad, b_gnt, b_rd, b_stb, b_done, hold, rel_cyc;

  initial begin
    rst_n = 1'b0; calibration_done = 1'b1;
    r0_req = 0; r0_write = 0; r0_addr = '0; r0_bl = '0; r0_wr_data = '0; r0_wr_mask = '0; r0_wr_stb = 0;
    r1_req = 0; r1_write = 0; r1_addr = '0; r1_bl = '0; r1_wr_data = '0; r1_wr_mask = '0; r1_wr_stb = 0;
    cmd_full = 0; wr_full = 0; wr_underrun = 0; wr_error = 0; rd_overflow = 0; rd_error = 0;
    rd_fill = 0;
    for (int i = 0; i < 16; i++) rd_mem[i] = 32'h0;

    // Reset state
    @(negedge clk); #1;
    chk("reset_outputs", 64'(|{r0_gnt, r1_gnt, r0_wr_rdy, r1_wr_rdy, r0_rd_stb, r1_rd_stb,
                               r0_done, r1_done, r0_error, r1_error, cmd_en, cmd_instr, cmd_bl,
                               cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en, r0_rd_data, r1_rd_data}), 64'd0);
    step(); rst_n = 1'b1;
    step();

    // 1: r0 write bl=3 at 0x100
    b_wr = n_wr; b_cmd = n_cmd; b_bad = n_bad;
    r0_req = 1; r0_write = 1; r0_addr = 30'h100; r0_bl = 6'd3;
    r0_wr_data = 32'hCAFE0001; r0_wr_mask = 4'h5; r0_wr_stb = 1;
    step(); r0_req = 0;
    wait_done(0, 30, ok, err);
    chk("t1_done", 64'(ok), 64'd1);
    chk("t1_error", 64'(err), 64'd0);
    chk("t1_wr_count", 64'(n_wr - b_wr), 64'd4);
    chk("t1_cmd_count", 64'(n_cmd - b_cmd), 64'd1);
    chk("t1_cmd_instr", 64'(m_instr), 64'd0);
    chk("t1_cmd_bl", 64'(m_bl), 64'd3);
    chk("t1_cmd_addr", 64'(m_addr), 64'h100);
    chk("t1_wr_data", 64'(m_wdata), 64'hCAFE0001);
    chk("t1_wr_mask", 64'(m_wmask), 64'h5);
    chk("t1_gnt_at_done", 64'(r0_gnt), 64'd1);
    @(negedge clk); #1;
    chk("t1_gnt_after_done", 64'(r0_gnt), 64'd0);
    step(); r0_wr_stb = 0;

    // 2: r1 read bl=1, FIFO returns A5, A6
    b_cmd = n_cmd; b_rd = rd1_log.size();
    rd_mem[0] = 32'hA5; rd_mem[1] = 32'hA6; rd_fill = 2;
    r1_req = 1; r1_write = 0; r1_addr = 30'h203; r1_bl = 6'd1;
    step(); r1_req = 0;
    wait_done(1, 30, ok, err);
    chk("t2_done", 64'(ok), 64'd1);
    chk("t2_error", 64'(err), 64'd0);
    chk("t2_cmd_instr", 64'(m_instr), 64'd1);
    chk("t2_cmd_addr", 64'(m_addr), 64'h200);
    chk("t2_stb_count", 64'(rd1_log.size() - b_rd), 64'd2);
    if (rd1_log.size() >= b_rd + 2) begin
      chk("t2_rd_word0", 64'(rd1_log[b_rd]), 64'hA5);
      chk("t2_rd_word1", 64'(rd1_log[b_rd + 1]), 64'hA6);
    end
    step();

    // 3: simultaneous requests alternate; calibration low blocks grants
    b_gnt = gnt_log.size(); b_bad = n_bad;
    r0_write = 1; r0_bl = 0; r0_wr_stb = 1;
    r1_write = 1; r1_bl = 0; r1_wr_stb = 1;
    r0_req = 1; r1_req = 1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (gnt_log.size() >= b_gnt + 4) break;
    end
    step(); r0_req = 0; r1_req = 0;
    repeat (15) step();
    chk("t3_grant_count_min", 64'(gnt_log.size() >= b_gnt + 4), 64'd1);
    if (gnt_log.size() >= b_gnt + 4) begin
      chk("t3_grant0", 64'(gnt_log[b_gnt]), 64'd0);
      chk("t3_grant1", 64'(gnt_log[b_gnt + 1]), 64'd1);
      chk("t3_grant2", 64'(gnt_log[b_gnt + 2]), 64'd0);
      chk("t3_grant3", 64'(gnt_log[b_gnt + 3]), 64'd1);
    end
    chk("t3_no_overlap", 64'(n_bad - b_bad), 64'd0);
    r0_wr_stb = 0; r1_wr_stb = 0;
    b_gnt = gnt_log.size();
    calibration_done = 0; r0_req = 1;
    repeat (10) step();
    chk("t3_nocal_gnt", 64'(r0_gnt), 64'd0);
    chk("t3_nocal_log", 64'(gnt_log.size() - b_gnt), 64'd0);
    r0_req = 0; step(); calibration_done = 1; step();

    // 4: wr_full toggling, bl=7, then cmd_full held 5 cycles
    b_wr = n_wr; b_cmd = n_cmd; b_bad = n_bad; b_done = n_done0; hold = 0; rel_cyc = -100;
    cmd_full = 1;
    r0_req = 1; r0_write = 1; r0_addr = 30'h3000; r0_bl = 6'd7; r0_wr_stb = 1; r0_wr_data = 32'h55AA55AA;
    step(); r0_req = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      wr_full = ~wr_full;
      if (n_wr - b_wr >= 8 && cmd_full) begin
        hold++;
        if (hold >= 5) begin cmd_full = 0; rel_cyc = cyc; end
      end
      if (n_done0 > b_done) break;
    end
    wr_full = 0; r0_wr_stb = 0;
    chk("t4_done", 64'(n_done0 - b_done), 64'd1);
    chk("t4_wr_count", 64'(n_wr - b_wr), 64'd8);
    chk("t4_no_bus_violation", 64'(n_bad - b_bad), 64'd0);
    chk("t4_cmd_count", 64'(n_cmd - b_cmd), 64'd1);
    chk("t4_cmd_after_release", 64'(cmd_cyc - rel_cyc), 64'd1);
    chk("t4_cmd_bl", 64'(m_bl), 64'd7);
    step();

    // 5a: read bl=3, two words then empty forever -> timeout
    rd_mem[2] = 32'h11; rd_mem[3] = 32'h22; rd_fill = 4; b_rd = rd0_log.size();
    r0_req = 1; r0_write = 0; r0_addr = 30'h400; r0_bl = 6'd3;
    step(); r0_req = 0;
    wait_done(0, 400, ok, err);
    chk("t5_timeout_done", 64'(ok), 64'd1);
    chk("t5_timeout_error", 64'(err), 64'd1);
    chk("t5_timeout_latency", 64'(cyc - last_stb_cyc), 64'd256);
    chk("t5_timeout_words", 64'(rd0_log.size() - b_rd), 64'd2);
    if (rd0_log.size() >= b_rd + 2) chk("t5_rd_word1", 64'(rd0_log[b_rd + 1]), 64'h22);
    step();

    // 5b: rd_error pulse mid-read
    rd_mem[4] = 32'h33; rd_mem[5] = 32'h44; rd_fill = 6; b_stb = n_stb1;
    r1_req = 1; r1_write = 0; r1_bl = 6'd1;
    step(); r1_req = 0; rd_error = 1;
    step(); rd_error = 0;
    wait_done(1, 30, ok, err);
    chk("t5_rderr_done", 64'(ok), 64'd1);
    chk("t5_rderr_error", 64'(err), 64'd1);
    chk("t5_rderr_words", 64'(n_stb1 - b_stb), 64'd2);
    step();

    // 6: async reset during WR_DATA, then lone r1 request
    r0_req = 1; r0_write = 1; r0_bl = 6'd7; r0_wr_stb = 1;
    step(); r0_req = 0;
    step(); step();
    @(negedge clk); #1;
    chk("t6_pre_gnt", 64'(r0_gnt), 64'd1);
    chk("t6_pre_wr_en", 64'(wr_en), 64'd1);
    #1 rst_n = 0;
    #1;
    chk("t6_reset_outputs", 64'(|{r0_gnt, r1_gnt, r0_wr_rdy, r1_wr_rdy, r0_rd_stb, r1_rd_stb,
                                  r0_done, r1_done, r0_error, r1_error, cmd_en, cmd_instr, cmd_bl,
                                  cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en}), 64'd0);
    step(); r0_wr_stb = 0; rst_n = 1;
    step();
    b_gnt = gnt_log.size();
    r1_req = 1; r1_write = 1; r1_bl = 6'd0; r1_wr_stb = 1; r1_wr_data = 32'h600D;
    step(); r1_req = 0;
    wait_done(1, 30, ok, err);
    chk("t6_r1_done", 64'(ok), 64'd1);
    chk("t6_r1_error", 64'(err), 64'd0);
    chk("t6_first_grant", 64'((gnt_log.size() > b_gnt) ? gnt_log[b_gnt] : -1), 64'd1);
    step(); r1_wr_stb = 0;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
